fifo_rd_packer: RTL and testbench

Read-side consumer for the 4-bit asynchronous FIFO, placed in the FIFO's read-clock domain. It drains nibbles through the FIFO's `r_en` / `mem_empty` / `data_out` interface and packs them into wide words. Each word is presented on a valid/ready output handshake, so downstream logic receives 16-bit words instead of a nibble stream. A `flush` input forces out a partially filled word.

---
 rtl/fifo_rd_packer.sv | 94 +++++++++
 tb/tb_fifo_rd_packer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - drains nibbles from the async FIFO read side and packs them into wide words
// Words leave on a valid/ready handshake; flush forces out a partially filled word.
module fifo_rd_packer #(
   parameter int DATA_W = 4,
   parameter int LANES  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mem_empty,
   output logic                      r_en,
   input  logic [DATA_W-1:0]         data_out,
   input  logic                      flush,
   output logic [DATA_W*LANES-1:0]   word_out,
   output logic [$clog2(LANES):0]    word_len,
   output logic                      word_valid,
   input  logic                      word_ready
);

   localparam int LW = $clog2(LANES) + 1;
   localparam logic [LW-1:0] LANES_C = LW'(LANES);

   typedef enum logic {FILL, HOLD} state_t;

   state_t                    state;
   logic [LW-1:0]             issued;
   logic [LW-1:0]             filled;
   logic                      pend;
   logic                      flush_lat;
   logic [DATA_W*LANES-1:0]   lanes;

   logic [LW-1:0]             next_filled;
   logic                      flush_hit;

   always_comb begin
      r_en        = (state == FILL) && !mem_empty && (issued < LANES_C) && !flush_lat;
      next_filled = filled + LW'(pend);
      // A flush only counts once something is captured or in flight.
      flush_hit   = flush_lat || (flush && ((filled != '0) || pend));
   end

   assign word_out = lanes;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FILL;
         issued     <= '0;
         filled     <= '0;
         pend       <= 1'b0;
         flush_lat  <= 1'b0;
         lanes      <= '0;
         word_len   <= '0;
         word_valid <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               pend <= r_en;
               if (r_en)
                  issued <= issued + LW'(1);
               if (pend) begin
                  for (int i = 0; i < LANES; i++)
                     if (filled == LW'(i))
                        lanes[i*DATA_W +: DATA_W] <= data_out;
                  filled <= next_filled;
               end
               if (flush_hit)
                  flush_lat <= 1'b1;
               if (pend && (next_filled == LANES_C)) begin
                  state      <= HOLD;
                  word_valid <= 1'b1;
                  word_len   <= LANES_C;
               end else if (flush_hit && !pend && !r_en) begin
                  // Nothing in flight any more, so the partial word is final.
                  state      <= HOLD;
                  word_valid <= 1'b1;
                  word_len   <= filled;
               end
            end
            HOLD: begin
               if (word_ready) begin
                  state      <= FILL;
                  word_valid <= 1'b0;
                  word_len   <= '0;
                  issued     <= '0;
                  filled     <= '0;
                  flush_lat  <= 1'b0;
                  lanes      <= '0;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed and randomized bench for fifo_rd_packer with a queue-based FIFO model
module tb_fifo_rd_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_empty;
   logic        r_en;
   logic [3:0]  data_out;
   logic        flush;
   logic [15:0] word_out;
   logic [2:0]  word_len;
   logic        word_valid;
   logic        word_ready;

   always #5 clk = ~clk;

   fifo_rd_packer #(.DATA_W(4), .LANES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_empty  (mem_empty),
      .r_en       (r_en),
      .data_out   (data_out),
      .flush      (flush),
      .word_out   (word_out),
      .word_len   (word_len),
      .word_valid (word_valid),
      .word_ready (word_ready)
   );

   int          vectors = 0;
   int          miscompares = 0;
   int          underflow = 0;
   int          stab_err = 0;
   logic [3:0]  fifo_q[$];
   logic [18:0] got[$];
   logic [3:0]  exp_nib[$];

   logic        s_ren, s_valid;
   logic [15:0] s_word;
   logic [2:0]  s_len;
   logic        hold_prev = 1'b0;
   logic [15:0] prev_w;
   logic [2:0]  prev_l;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] n);
      fifo_q.push_back(n);
      mem_empty = 1'b0;
   endtask

   // One cycle: sample outputs mid-cycle, then model the FIFO's 1-cycle read latency.
   task automatic tick();
      logic ren;
      @(negedge clk);
      s_ren   = r_en;
      s_valid = word_valid;
      s_word  = word_out;
      s_len   = word_len;
      if (r_en && mem_empty) underflow++;
      if (hold_prev && !rst)
         if (!word_valid || word_out !== prev_w || word_len !== prev_l || r_en) stab_err++;
      hold_prev = word_valid && !word_ready && !rst;
      prev_w = word_out;
      prev_l = word_len;
      if (word_valid && word_ready && !rst) got.push_back({word_len, word_out});
      ren = r_en;
      @(posedge clk);
      #1;
      if (ren) begin
         if (fifo_q.size() > 0) data_out = fifo_q.pop_front();
         else data_out = 'x;
      end
      mem_empty = (fifo_q.size() == 0);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!s_valid && n < 60);
      check({tag, "_timeout"}, 32'(s_valid), 32'd1);
   endtask

   logic [9:0]  ren_v, val_v;
   logic [15:0] w1;
   logic [2:0]  l1;
   int          dev, vcount, rcount, nwords, npushed, guard;
   logic [3:0]  nib;
   logic [15:0] exp_w;

   initial begin
      rst = 1'b1; flush = 1'b0; word_ready = 1'b0; mem_empty = 1'b1; data_out = 4'h0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_valid", 32'(s_valid), 32'd0);
      check("rst_word",  32'(s_word),  32'd0);
      check("rst_len",   32'(s_len),   32'd0);
      check("rst_ren",   32'(s_ren),   32'd0);

      // Full word, back-to-back reads, always-ready sink
      word_ready = 1'b1;
      push(4'h3); push(4'h9); push(4'h7); push(4'hF);
      w1 = '0; l1 = '0;
      for (int i = 0; i < 10; i++) begin
         tick();
         ren_v[i] = s_ren;
         val_v[i] = s_valid;
         if (s_valid) begin w1 = s_word; l1 = s_len; end
      end
      check("full_ren_pattern",   32'(ren_v), 32'h00F);
      check("full_valid_pattern", 32'(val_v), 32'h020);
      check("full_word", 32'(w1), 32'hF793);
      check("full_len",  32'(l1), 32'd4);

      // Empty stall: two nibbles, then a long gap before the rest
      push(4'h3); push(4'h9);
      rcount = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s_ren) rcount++;
      end
      check("stall_reads", 32'(rcount), 32'd2);
      check("stall_no_valid", 32'(s_valid), 32'd0);
      push(4'h7); push(4'hF);
      wait_valid("stall");
      check("stall_word", 32'(s_word), 32'hF793);
      check("stall_len",  32'(s_len),  32'd4);
      tick();

      // Backpressure while the next nibble waits in the FIFO
      word_ready = 1'b0;
      push(4'h1); push(4'h2); push(4'h3); push(4'h4);
      wait_valid("bp");
      check("bp_word", 32'(s_word), 32'h4321);
      push(4'h5);
      dev = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!(s_valid && s_word == 16'h4321 && s_len == 3'd4 && !s_ren)) dev++;
      end
      check("bp_stable", 32'(dev), 32'd0);
      word_ready = 1'b1;
      tick();
      check("bp_hs_valid", 32'(s_valid), 32'd1);
      tick();
      check("bp_after_valid", 32'(s_valid), 32'd0);
      check("bp_after_ren",   32'(s_ren),   32'd1);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      check("bp_flush1_valid", 32'(s_valid), 32'd1);
      check("bp_flush1_word",  32'(s_word),  32'h0005);
      check("bp_flush1_len",   32'(s_len),   32'd1);
      tick();

      // Partial flush with no read in flight: valid the next cycle
      push(4'h3); push(4'h9);
      repeat (3) tick();
      flush = 1'b1;
      tick();
      check("pflush_f_valid", 32'(s_valid), 32'd0);
      flush = 1'b0;
      tick();
      check("pflush_f1_valid", 32'(s_valid), 32'd1);
      check("pflush_word", 32'(s_word), 32'h0093);
      check("pflush_len",  32'(s_len),  32'd2);
      tick();

      // Flush with nothing captured is ignored
      flush = 1'b1;
      tick();
      flush = 1'b0;
      vcount = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (s_valid) vcount++;
      end
      check("empty_flush_valid", 32'(vcount), 32'd0);

      // Flush while a read is pending: valid two cycles later
      push(4'hA); push(4'hB);
      repeat (2) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      check("pend_flush_f1_valid", 32'(s_valid), 32'd0);
      tick();
      check("pend_flush_f2_valid", 32'(s_valid), 32'd1);
      check("pend_flush_word", 32'(s_word), 32'h00BA);
      check("pend_flush_len",  32'(s_len),  32'd2);
      tick();

      // Reset with two lanes captured and one read in flight
      push(4'h3); push(4'h9); push(4'h7);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("midrst_valid", 32'(s_valid), 32'd0);
      check("midrst_word",  32'(s_word),  32'd0);
      check("midrst_len",   32'(s_len),   32'd0);
      check("midrst_ren",   32'(s_ren),   32'd0);
      push(4'hA); push(4'hB); push(4'hC); push(4'hD);
      wait_valid("midrst");
      check("midrst_next_word", 32'(s_word), 32'hDCBA);
      tick();

      // Random phase: sparse writes, random sink readiness, words must be consecutive 4-nibble chunks
      got.delete();
      nwords = 30;
      npushed = 0;
      guard = 0;
      while (got.size() < nwords && guard < 4000) begin
         word_ready = 1'($urandom_range(0, 1));
         if (npushed < 4 * nwords && $urandom_range(0, 2) != 0) begin
            nib = 4'($urandom_range(0, 15));
            push(nib);
            exp_nib.push_back(nib);
            npushed++;
         end
         tick();
         guard++;
      end
      check("rand_word_count", 32'(got.size()), 32'(nwords));
      for (int i = 0; i < nwords && i < got.size(); i++) begin
         exp_w = '0;
         for (int j = 0; j < 4; j++) exp_w[j*4 +: 4] = exp_nib[i*4 + j];
         check($sformatf("rand_word_%0d", i), 32'(got[i]), {13'd0, 3'd4, exp_w});
      end

      check("no_underflow", 32'(underflow), 32'd0);
      check("hold_stable",  32'(stab_err),  32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
